tlb_ctrl: RTL and testbench
===========================

Name: tlb_ctrl

Overview:
- TLB array and control, and the responder for the CP0 TLB interface.
- Accepts TLBP/TLBR/TLBWI (optional TLBWR) commands from CP0 and returns probe result / read entry on a response strobe. CP0 consumes the strobe and updates Index/EntryHi/EntryLo0/EntryLo1.
- Provides two combinational lookup ports for the fetch and memory stages.
- Probe is a multi-cycle sequential search to keep the CAM compare off the critical path.

Parameters:
TLBNUM, 16, number of entries; power of two, multiple of PROBE_LANES
PROBE_LANES, 4, entries compared per probe cycle
IDXW, 4, index width, equal to log2(TLBNUM)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request from CP0
cmd_ready  out  1  high only in IDLE with flush low
cmd_op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
cmd_entryhi  in  32  CP0 EntryHi: vpn2 [31:13], asid [7:0]
cmd_entrylo0  in  32  CP0 EntryLo0: pfn [25:6], c [5:3], d [2], v [1], g [0]
cmd_entrylo1  in  32  CP0 EntryLo1, same layout
cmd_index  in  IDXW  CP0 Index.index
flush  in  1  exception/eret flush; aborts an in-flight probe
resp_valid  out  1  one-cycle response pulse
resp_op  out  2  opcode of the command being answered
resp_found  out  1  TLBP match found
resp_index  out  IDXW  TLBP matching index
r_vpn2/r_asid/r_g  out  19/8/1  TLBR entry tag
r_pfn0/r_c0/r_d0/r_v0  out  20/3/1/1  TLBR even page
r_pfn1/r_c1/r_d1/r_v1  out  20/3/1/1  TLBR odd page
s0_vpn2 / s1_vpn2  in  19  lookup virtual page pair
s0_odd / s1_odd  in  1  VA bit 12
s0_asid / s1_asid  in  8  current ASID
s0_found / s1_found  out  1  lookup hit
s0_index / s1_index  out  IDXW  hit index
s0_pfn / s1_pfn  out  20  selected page frame
s0_cdv / s1_cdv  out  5  {c,d,v} of the selected page

Behaviour:
- Reset (async, resetn=0): all entry fields 0; state IDLE; resp_valid, resp_found, resp_index, resp_op and all r_* outputs 0. Reset asserted mid-probe aborts it with no response.
- Match rule: entry.vpn2==vpn2 && (entry.g || entry.asid==asid). Lowest index wins on multiple matches.
- Lookup ports: purely combinational, independent of the FSM. A write at edge N is visible to lookups from cycle N+1. During the write cycle, lookups see the old contents.
- Handshake: a command is accepted when cmd_valid && cmd_ready. The cmd_* fields are sampled at accept only. Exactly one resp_valid pulse per accepted, unflushed command. No backpressure.
- TLBWI: the entry at cmd_index is written at the accept edge. g = lo0.g & lo1.g. resp_valid in the next cycle. Latency 1.
- TLBR: r_* register the entry at cmd_index at the accept edge. resp_valid in the next cycle. r_* hold until the next TLBR.
- TLBP FSM IDLE -> PROBE -> RESP -> IDLE.
  - Accept latches vpn2/asid and clears group counter grp.
  - Each PROBE cycle compares entries grp*PROBE_LANES .. +PROBE_LANES-1.
  - First hit: register found=1 and index, then go to RESP.
  - Else grp++; after the last group, found=0, index unchanged, go to RESP.
  - RESP asserts resp_valid for one cycle, then IDLE.
  - Worst-case latency is TLBNUM/PROBE_LANES+1 cycles, i.e. 5 at default.
- TLBWI and TLBR also pass through RESP, so cmd_ready is low for one cycle after any accept.
- flush: forces IDLE from PROBE or RESP, suppresses resp_valid, and deasserts cmd_ready in the same cycle. Array writes already committed remain.
- grp counter width is log2(TLBNUM/PROBE_LANES) and never wraps inside one probe.

Optional Feature:
TLB_RANDOM_EN
- Defined:
  - Random counter rnd[IDXW-1:0] resets to TLBNUM-1 and decrements every clock, wrapping 0 -> TLBNUM-1.
  - TLBWR writes entry rnd sampled at the accept edge; it behaves like TLBWI otherwise.
  - resp_index returns the written index.
- Undefined: op 11 is accepted as a no-op; it responds after 1 cycle with resp_found=0 and no array change.

Decomposition:
- Shared package (mycpu.h): TLBNUM, opcode constants TLB_OP_P/R/WI/WR, and CP0 field bit positions.
- One sub-module, tlb_entry_match: combinational single-entry tag compare. Instantiated PROBE_LANES times for the probe and TLBNUM times per lookup port.

Test Plan:
1. TLBWI index 5 with vpn2=0x12345, asid 0x3, g=0, lo0.pfn=0xABCDE, v0=1 -> resp_valid 1 cycle later. A lookup with vpn2 0x12345, asid 3, odd 0 the following cycle gives found=1, index 5, pfn 0xABCDE.
2. TLBP for the entry in slot 13 -> resp_valid 5 cycles after accept, found=1, index 13. TLBP miss -> 5 cycles, found=0.
3. Entries 2 and 9 both match (entry 9 g=1, asid mismatch) -> probe returns index 2 after 2 cycles. A lookup also returns 2.
4. TLBR index 7 -> r_* equal the written fields next cycle; g reflects lo0.g & lo1.g.
5. flush asserted in the 2nd PROBE cycle -> no resp_valid; cmd_ready high the following cycle. resetn low mid-probe -> all outputs 0, lookups miss.
6. TLB_RANDOM_EN: TLBWR at a known cycle -> written index equals the rnd value at the accept edge, and rnd wraps 0 -> 15.

Source files
------------

// File: rtl/tlb_ctrl_pkg.sv
// tlb_ctrl_pkg -- shared TLB definitions.
//   TLBNUM          default number of TLB entries
//   TLB_OP_*        CP0 TLB command opcodes carried on cmd_op / resp_op
//   EHI_* / ELO_*   bit positions of the CP0 EntryHi / EntryLo fields
//   tlb_entry_t     one stored TLB entry (tag plus even/odd page pair)
package tlb_ctrl_pkg;

  localparam int TLBNUM = 16;
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;

  localparam logic [1:0] TLB_OP_P  = 2'b00;
  localparam logic [1:0] TLB_OP_R  = 2'b01;
  localparam logic [1:0] TLB_OP_WI = 2'b10;
  localparam logic [1:0] TLB_OP_WR = 2'b11;

  localparam int EHI_VPN2_MSB = 31;
  localparam int EHI_VPN2_LSB = 13;
  localparam int EHI_ASID_MSB = 7;
  localparam int EHI_ASID_LSB = 0;

  localparam int ELO_PFN_MSB = 25;
  localparam int ELO_PFN_LSB = 6;
  localparam int ELO_C_MSB   = 5;
  localparam int ELO_C_LSB   = 3;
  localparam int ELO_D       = 2;
  localparam int ELO_V       = 1;
  localparam int ELO_G       = 0;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_ctrl_entry_match.sv
// tlb_entry_match -- combinational tag compare for a single TLB entry.
//   e_vpn2/e_asid/e_g  stored entry tag
//   vpn2/asid          searched virtual page pair and current ASID
//   hit                entry matches (global entries ignore the ASID)
module tlb_entry_match
  import tlb_ctrl_pkg::*;
(
  input  logic [VPN2_W-1:0] e_vpn2,
  input  logic [ASID_W-1:0] e_asid,
  input  logic              e_g,
  input  logic [VPN2_W-1:0] vpn2,
  input  logic [ASID_W-1:0] asid,
  output logic              hit
);

  assign hit = (e_vpn2 == vpn2) && (e_g || (e_asid == asid));

endmodule

// File: rtl/tlb_ctrl.sv
// tlb_ctrl -- TLB array, CP0 TLB command responder and two lookup ports.
//   clk, resetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op     CP0 command handshake (TLBP/TLBR/TLBWI/TLBWR)
//   cmd_entryhi/lo0/lo1/index      CP0 register values sampled at accept
//   flush                          aborts an in-flight command, blocks accept
//   resp_valid/op/found/index      one-cycle response pulse and probe result
//   r_*                            entry read by the last TLBR
//   s0_* / s1_*                    combinational fetch / memory lookup ports
// Build option: define TLB_RANDOM_EN to implement TLBWR with a free-running
// random index; otherwise TLBWR is accepted and answered as a no-op.
module tlb_ctrl #(
  parameter int TLBNUM      = tlb_ctrl_pkg::TLBNUM,
  parameter int PROBE_LANES = 4,
  parameter int IDXW        = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_entryhi,
  input  logic [31:0]     cmd_entrylo0,
  input  logic [31:0]     cmd_entrylo1,
  input  logic [IDXW-1:0] cmd_index,
  input  logic            flush,
  output logic            resp_valid,
  output logic [1:0]      resp_op,
  output logic            resp_found,
  output logic [IDXW-1:0] resp_index,
  output logic [18:0]     r_vpn2,
  output logic [7:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_pfn0,
  output logic [2:0]      r_c0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_pfn1,
  output logic [2:0]      r_c1,
  output logic            r_d1,
  output logic            r_v1,
  input  logic [18:0]     s0_vpn2,
  input  logic            s0_odd,
  input  logic [7:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_pfn,
  output logic [4:0]      s0_cdv,
  input  logic [18:0]     s1_vpn2,
  input  logic            s1_odd,
  input  logic [7:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_pfn,
  output logic [4:0]      s1_cdv
);
  import tlb_ctrl_pkg::*;

  localparam int NGRP = TLBNUM / PROBE_LANES;
  localparam int GRPW = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state;
  logic [GRPW-1:0]   grp;
  logic [VPN2_W-1:0] probe_vpn2;
  logic [ASID_W-1:0] probe_asid;
  tlb_entry_t        tlb [TLBNUM];
  tlb_entry_t        wr_entry;
  logic              accept;
  logic              wr_en;
  logic [IDXW-1:0]   wr_idx;
  logic              unused_cmd_bits;

  assign cmd_ready  = (state == S_IDLE) && !flush;
  assign accept     = cmd_valid && cmd_ready;
  assign resp_valid = (state == S_RESP) && !flush;

  assign unused_cmd_bits = ^{cmd_entryhi[EHI_VPN2_LSB-1:EHI_ASID_MSB+1],
                             cmd_entrylo0[31:ELO_PFN_MSB+1],
                             cmd_entrylo1[31:ELO_PFN_MSB+1]};

  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = cmd_entryhi[EHI_VPN2_MSB:EHI_VPN2_LSB];
    wr_entry.asid = cmd_entryhi[EHI_ASID_MSB:EHI_ASID_LSB];
    // A pair is global only if both halves say so.
    wr_entry.g    = cmd_entrylo0[ELO_G] & cmd_entrylo1[ELO_G];
    wr_entry.pfn0 = cmd_entrylo0[ELO_PFN_MSB:ELO_PFN_LSB];
    wr_entry.c0   = cmd_entrylo0[ELO_C_MSB:ELO_C_LSB];
    wr_entry.d0   = cmd_entrylo0[ELO_D];
    wr_entry.v0   = cmd_entrylo0[ELO_V];
    wr_entry.pfn1 = cmd_entrylo1[ELO_PFN_MSB:ELO_PFN_LSB];
    wr_entry.c1   = cmd_entrylo1[ELO_C_MSB:ELO_C_LSB];
    wr_entry.d1   = cmd_entrylo1[ELO_D];
    wr_entry.v1   = cmd_entrylo1[ELO_V];
  end

`ifdef TLB_RANDOM_EN
  logic [IDXW-1:0] rnd;

  // Free-running down counter; natural wrap 0 -> TLBNUM-1 since TLBNUM is 2^IDXW.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rnd <= IDXW'(TLBNUM - 1);
    else         rnd <= rnd - 1'b1;
  end

  assign wr_en  = accept && ((cmd_op == TLB_OP_WI) || (cmd_op == TLB_OP_WR));
  assign wr_idx = (cmd_op == TLB_OP_WR) ? rnd : cmd_index;
`else
  assign wr_en  = accept && (cmd_op == TLB_OP_WI);
  assign wr_idx = cmd_index;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
    end else if (wr_en) begin
      tlb[wr_idx] <= wr_entry;
    end
  end

  // Probe datapath: one group of PROBE_LANES entries compared per cycle.
  logic [PROBE_LANES-1:0] lane_hit;
  logic                   probe_hit;
  logic [IDXW-1:0]        probe_idx;

  for (genvar l = 0; l < PROBE_LANES; l++) begin : g_lane
    logic [IDXW-1:0] eidx;
    assign eidx = IDXW'(int'(grp) * PROBE_LANES + l);
    tlb_entry_match u_match (
      .e_vpn2 (tlb[eidx].vpn2),
      .e_asid (tlb[eidx].asid),
      .e_g    (tlb[eidx].g),
      .vpn2   (probe_vpn2),
      .asid   (probe_asid),
      .hit    (lane_hit[l])
    );
  end

  // Scan downward so the lowest matching lane is the one that sticks.
  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int l = PROBE_LANES - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        probe_hit = 1'b1;
        probe_idx = IDXW'(int'(grp) * PROBE_LANES + l);
      end
    end
  end

  // Probe key is data only; it is qualified by the FSM state.
  always_ff @(posedge clk) begin
    if (accept && (cmd_op == TLB_OP_P)) begin
      probe_vpn2 <= cmd_entryhi[EHI_VPN2_MSB:EHI_VPN2_LSB];
      probe_asid <= cmd_entryhi[EHI_ASID_MSB:EHI_ASID_LSB];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grp        <= '0;
      resp_op    <= 2'b00;
      resp_found <= 1'b0;
      resp_index <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            resp_op <= cmd_op;
            if (cmd_op == TLB_OP_P) begin
              grp   <= '0;
              state <= S_PROBE;
            end else begin
              resp_found <= 1'b0;
`ifdef TLB_RANDOM_EN
              if (cmd_op == TLB_OP_WR) resp_index <= rnd;
`endif
              state <= S_RESP;
            end
          end
        end
        S_PROBE: begin
          if (probe_hit) begin
            resp_found <= 1'b1;
            resp_index <= probe_idx;
            state      <= S_RESP;
          end else if (grp == GRPW'(NGRP - 1)) begin
            resp_found <= 1'b0;
            state      <= S_RESP;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // TLBR read-out registers, held until the next TLBR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vpn2 <= '0; r_asid <= '0; r_g  <= 1'b0;
      r_pfn0 <= '0; r_c0   <= '0; r_d0 <= 1'b0; r_v0 <= 1'b0;
      r_pfn1 <= '0; r_c1   <= '0; r_d1 <= 1'b0; r_v1 <= 1'b0;
    end else if (accept && (cmd_op == TLB_OP_R)) begin
      r_vpn2 <= tlb[cmd_index].vpn2;
      r_asid <= tlb[cmd_index].asid;
      r_g    <= tlb[cmd_index].g;
      r_pfn0 <= tlb[cmd_index].pfn0;
      r_c0   <= tlb[cmd_index].c0;
      r_d0   <= tlb[cmd_index].d0;
      r_v0   <= tlb[cmd_index].v0;
      r_pfn1 <= tlb[cmd_index].pfn1;
      r_c1   <= tlb[cmd_index].c1;
      r_d1   <= tlb[cmd_index].d1;
      r_v1   <= tlb[cmd_index].v1;
    end
  end

  // Lookup ports: full parallel compare, independent of the FSM.
  logic [VPN2_W-1:0] lk_vpn2  [2];
  logic [ASID_W-1:0] lk_asid  [2];
  logic              lk_odd   [2];
  logic              lk_found [2];
  logic [IDXW-1:0]   lk_idx   [2];
  logic [PFN_W-1:0]  lk_pfn   [2];
  logic [4:0]        lk_cdv   [2];

  assign lk_vpn2[0] = s0_vpn2;
  assign lk_asid[0] = s0_asid;
  assign lk_odd[0]  = s0_odd;
  assign lk_vpn2[1] = s1_vpn2;
  assign lk_asid[1] = s1_asid;
  assign lk_odd[1]  = s1_odd;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TLBNUM-1:0] hit;
    logic              found;
    logic [IDXW-1:0]   idx;

    for (genvar e = 0; e < TLBNUM; e++) begin : g_ent
      tlb_entry_match u_match (
        .e_vpn2 (tlb[e].vpn2),
        .e_asid (tlb[e].asid),
        .e_g    (tlb[e].g),
        .vpn2   (lk_vpn2[p]),
        .asid   (lk_asid[p]),
        .hit    (hit[e])
      );
    end

    always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int e = TLBNUM - 1; e >= 0; e--) begin
        if (hit[e]) begin
          found = 1'b1;
          idx   = IDXW'(e);
        end
      end
    end

    assign lk_found[p] = found;
    assign lk_idx[p]   = idx;
    assign lk_pfn[p]   = !found    ? '0 :
                         lk_odd[p] ? tlb[idx].pfn1 : tlb[idx].pfn0;
    assign lk_cdv[p]   = !found    ? '0 :
                         lk_odd[p] ? {tlb[idx].c1, tlb[idx].d1, tlb[idx].v1}
                                   : {tlb[idx].c0, tlb[idx].d0, tlb[idx].v0};
  end

  assign s0_found = lk_found[0];
  assign s0_index = lk_idx[0];
  assign s0_pfn   = lk_pfn[0];
  assign s0_cdv   = lk_cdv[0];
  assign s1_found = lk_found[1];
  assign s1_index = lk_idx[1];
  assign s1_pfn   = lk_pfn[1];
  assign s1_cdv   = lk_cdv[1];

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl -- directed scoreboard bench for tlb_ctrl.
// Expected responses are queued when a command is driven and matched against
// resp_valid pulses (cycle, opcode, found, index). Honours TLB_RANDOM_EN.
module tb_tlb_ctrl;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_entryhi, cmd_entrylo0, cmd_entrylo1;
  logic [3:0]  cmd_index;
  logic        flush;
  logic        resp_valid;
  logic [1:0]  resp_op;
  logic        resp_found;
  logic [3:0]  resp_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd, s1_odd;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [4:0]  s0_cdv, s1_cdv;

  tlb_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_entryhi(cmd_entryhi), .cmd_entrylo0(cmd_entrylo0),
    .cmd_entrylo1(cmd_entrylo1), .cmd_index(cmd_index), .flush(flush),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_found(resp_found),
    .resp_index(resp_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_cdv(s0_cdv),
    .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_cdv(s1_cdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         exp_cyc;
    logic [1:0] op;
    logic       found;
    logic [3:0] idx;
    bit         chk_idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef TLB_RANDOM_EN
  logic [3:0] rnd_m;
  logic [3:0] last_rnd;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rnd_m <= 4'hF;
    else         rnd_m <= rnd_m - 4'd1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ehi(input logic [18:0] vpn2, input logic [7:0] asid);
    return {vpn2, 5'b0, asid};
  endfunction

  function automatic logic [31:0] elo(input logic [19:0] pfn, input logic [2:0] c,
                                      input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

  // Response monitor: pops the scoreboard on each pulse, flags late/extra ones.
  always @(negedge clk) begin
    if (resetn) begin
      if (q.size() > 0 && cyc > q[0].exp_cyc) begin
        chk("resp_missing", {31'b0, resp_valid}, 32'd1);
        void'(q.pop_front());
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("resp_cycle", cyc, mon_e.exp_cyc);
          chk("resp_op", {30'b0, resp_op}, {30'b0, mon_e.op});
          chk("resp_found", {31'b0, resp_found}, {31'b0, mon_e.found});
          if (mon_e.chk_idx) chk("resp_index", {28'b0, resp_index}, {28'b0, mon_e.idx});
        end
      end
    end
  end

  // Drive one command; returns at the negedge right after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [3:0] idx, input int lat,
                       input logic efound, input logic [3:0] eidx, input bit chk_idx,
                       input bit want);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_entryhi = hi;
    cmd_entrylo0 = lo0; cmd_entrylo1 = lo1; cmd_index = idx;
    e.exp_cyc = cyc + lat; e.op = op; e.found = efound;
    e.idx = eidx; e.chk_idx = chk_idx;
`ifdef TLB_RANDOM_EN
    if (op == 2'b11) begin
      e.idx = rnd_m;
      last_rnd = rnd_m;
    end
`endif
    if (want) q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; flush = 1'b0;
    cmd_entryhi = '0; cmd_entrylo0 = '0; cmd_entrylo1 = '0; cmd_index = '0;
    s0_vpn2 = 19'h12345; s0_asid = 8'h03; s0_odd = 1'b0;
    s1_vpn2 = 19'h12345; s1_asid = 8'h04; s1_odd = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_found", {31'b0, resp_found}, 32'd0);
    chk("rst_resp_index", {28'b0, resp_index}, 32'd0);
    chk("rst_resp_op", {30'b0, resp_op}, 32'd0);
    chk("rst_r_vpn2", {13'b0, r_vpn2}, 32'd0);
    chk("rst_r_pfn1", {12'b0, r_pfn1}, 32'd0);
    chk("rst_s0_found", {31'b0, s0_found}, 32'd0);
    resetn = 1'b1;

    // TLBWI slot 5, then lookup on the following cycle
    issue(2'b10, ehi(19'h12345, 8'h03), elo(20'hABCDE, 3'd0, 1'b0, 1'b1, 1'b0),
          elo(20'h0, 3'd0, 1'b0, 1'b0, 1'b0), 4'd5, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    chk("wi5_s0_found", {31'b0, s0_found}, 32'd1);
    chk("wi5_s0_index", {28'b0, s0_index}, 32'd5);
    chk("wi5_s0_pfn", {12'b0, s0_pfn}, 32'hABCDE);
    chk("wi5_s0_cdv", {27'b0, s0_cdv}, 32'h01);
    chk("wi5_s1_asid_miss", {31'b0, s1_found}, 32'd0);
    drain("drain_wi5");

    // Populate slots 13, 2 and 9 (9 is global)
    issue(2'b10, ehi(19'h00D0D, 8'h11), elo(20'h13131, 3'd2, 1'b1, 1'b1, 1'b0),
          elo(20'h31313, 3'd0, 1'b0, 1'b1, 1'b0), 4'd13, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    issue(2'b10, ehi(19'h02222, 8'h05), elo(20'h02020, 3'd0, 1'b0, 1'b1, 1'b0),
          elo(20'h02021, 3'd0, 1'b0, 1'b1, 1'b0), 4'd2, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    issue(2'b10, ehi(19'h02222, 8'h77), elo(20'h09090, 3'd0, 1'b0, 1'b1, 1'b1),
          elo(20'h09091, 3'd0, 1'b1, 1'b1, 1'b1), 4'd9, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    drain("drain_fill");

    // TLBP: last-group hit, full miss, lowest-index priority, global match
    issue(2'b00, ehi(19'h00D0D, 8'h11), '0, '0, 4'd0, 5, 1'b1, 4'd13, 1'b1, 1'b1);
    drain("drain_p13");
    issue(2'b00, ehi(19'h7FFFF, 8'h11), '0, '0, 4'd0, 5, 1'b0, 4'd13, 1'b1, 1'b1);
    drain("drain_pmiss");
    issue(2'b00, ehi(19'h02222, 8'h05), '0, '0, 4'd0, 2, 1'b1, 4'd2, 1'b1, 1'b1);
    drain("drain_p2");
    issue(2'b00, ehi(19'h02222, 8'h30), '0, '0, 4'd0, 4, 1'b1, 4'd9, 1'b1, 1'b1);
    drain("drain_p9");

    s0_vpn2 = 19'h02222; s0_asid = 8'h05; s0_odd = 1'b0;
    s1_vpn2 = 19'h02222; s1_asid = 8'h30; s1_odd = 1'b1;
    #1;
    chk("lk_prio_index", {28'b0, s0_index}, 32'd2);
    chk("lk_prio_pfn", {12'b0, s0_pfn}, 32'h02020);
    chk("lk_global_index", {28'b0, s1_index}, 32'd9);
    chk("lk_global_pfn1", {12'b0, s1_pfn}, 32'h09091);
    chk("lk_global_cdv1", {27'b0, s1_cdv}, 32'h03);

    // TLBR: g is the AND of both halves
    issue(2'b10, ehi(19'h1ABCD, 8'h42), elo(20'h11111, 3'd3, 1'b1, 1'b1, 1'b1),
          elo(20'h22222, 3'd5, 1'b0, 1'b1, 1'b0), 4'd7, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    issue(2'b01, '0, '0, '0, 4'd7, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("tlbr7_vpn2", {13'b0, r_vpn2}, 32'h1ABCD);
    chk("tlbr7_asid", {24'b0, r_asid}, 32'h42);
    chk("tlbr7_g", {31'b0, r_g}, 32'd0);
    chk("tlbr7_even", {8'b0, r_pfn0, r_c0, r_d0, r_v0}, {8'b0, 20'h11111, 3'd3, 1'b1, 1'b1});
    chk("tlbr7_odd", {8'b0, r_pfn1, r_c1, r_d1, r_v1}, {8'b0, 20'h22222, 3'd5, 1'b0, 1'b1});
    issue(2'b10, ehi(19'h00888, 8'h08), elo(20'h0AAAA, 3'd1, 1'b0, 1'b1, 1'b1),
          elo(20'h0BBBB, 3'd1, 1'b0, 1'b1, 1'b1), 4'd8, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    issue(2'b01, '0, '0, '0, 4'd8, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("tlbr8_g", {31'b0, r_g}, 32'd1);
    chk("tlbr8_pfn1", {12'b0, r_pfn1}, 32'h0BBBB);
    drain("drain_tlbr");

    // TLBWR
    s0_vpn2 = 19'h5A5A5; s0_asid = 8'h09; s0_odd = 1'b0;
`ifdef TLB_RANDOM_EN
    issue(2'b11, ehi(19'h5A5A5, 8'h09), elo(20'h5A5A5, 3'd0, 1'b0, 1'b1, 1'b0),
          elo(20'h00006, 3'd0, 1'b0, 1'b1, 1'b0), 4'd0, 1, 1'b0, 4'd0, 1'b1, 1'b1);
    #1;
    chk("tlbwr_lk_found", {31'b0, s0_found}, 32'd1);
    chk("tlbwr_lk_index", {28'b0, s0_index}, {28'b0, last_rnd});
    drain("drain_wr");
    begin
      int guard;
      guard = 0;
      while (rnd_m != 4'd0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    // Next drive lands one edge after rnd hits 0, so the sampled index is 15.
    issue(2'b11, ehi(19'h5A5A6, 8'h09), elo(20'h00007, 3'd0, 1'b0, 1'b1, 1'b0),
          elo(20'h00008, 3'd0, 1'b0, 1'b1, 1'b0), 4'd0, 1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("tlbwr_wrap_index", {28'b0, last_rnd}, 32'd15);
    drain("drain_wr_wrap");
`else
    issue(2'b11, ehi(19'h5A5A5, 8'h09), elo(20'h5A5A5, 3'd0, 1'b0, 1'b1, 1'b0),
          elo(20'h00006, 3'd0, 1'b0, 1'b1, 1'b0), 4'd0, 1, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    chk("tlbwr_noop_lk_miss", {31'b0, s0_found}, 32'd0);
    drain("drain_wr");
`endif

    // flush in IDLE blocks cmd_ready combinationally
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", {31'b0, cmd_ready}, 32'd0);
    flush = 1'b0;
    #1;
    chk("idle_ready", {31'b0, cmd_ready}, 32'd1);

    // flush during the 2nd PROBE cycle: no response, ready right after
    issue(2'b00, ehi(19'h7FFFF, 8'h00), '0, '0, 4'd0, 5, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_probe_ready", {31'b0, cmd_ready}, 32'd0);
    chk("flush_probe_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", {31'b0, cmd_ready}, 32'd1);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-probe
    issue(2'b00, ehi(19'h7FFFF, 8'h00), '0, '0, 4'd0, 5, 1'b0, 4'd0, 1'b0, 1'b0);
    resetn = 1'b0;
    s0_vpn2 = 19'h12345; s0_asid = 8'h03; s0_odd = 1'b0;
    s1_vpn2 = 19'h02222; s1_asid = 8'h05; s1_odd = 1'b0;
    #1;
    chk("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_found", {31'b0, resp_found}, 32'd0);
    chk("rst_mid_index", {28'b0, resp_index}, 32'd0);
    chk("rst_mid_r_vpn2", {13'b0, r_vpn2}, 32'd0);
    chk("rst_mid_s0_miss", {31'b0, s0_found}, 32'd0);
    chk("rst_mid_s1_miss", {31'b0, s1_found}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);

    // All-zero array after reset: every entry matches vpn2 0/asid 0, slot 0 wins
    issue(2'b00, ehi(19'h00000, 8'h00), '0, '0, 4'd0, 2, 1'b1, 4'd0, 1'b1, 1'b1);
    drain("drain_zero_probe");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
